qed_inst_constraint_seq: RTL and testbench

- Parametrised, stateful successor to the QED instruction-legality constraint.
- Decodes the fetched RV32I instruction against a configurable register/immediate envelope, then gates legality by a QED phase state machine (ORIG → DUP → DONE).
- Also enforces a store-spacing window and an original/duplicate instruction-count balance.
- Output `allowed` is consumed by a formal wrapper assume; this block itself contains no assume/assert.

---
 rtl/qed_inst_constraint_seq.sv | 152 +++++++++++++++
 tb/tb_qed_inst_constraint_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/qed_inst_constraint_seq.sv
// rtl/qed_inst_constraint_seq.sv - stateful QED instruction-legality constraint (ORIG/DUP/DONE)
module qed_inst_constraint_seq #(
  parameter int NUM_REGS      = 16,
  parameter int MEM_IMM_LIMIT = 64,
  parameter int PC_DEP_RD0    = 1,
  parameter int STORE_GAP     = 2,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             instr_valid,
  input  logic             sif_commit,
  output logic             allowed,
  output logic             accept,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             store_block
);

  typedef enum logic [1:0] {
    ORIG = 2'd0,
    DUP  = 2'd1,
    DONE = 2'd2
  } phase_t;

  localparam logic [5:0]       REG_LIM  = 6'(NUM_REGS);
  localparam logic [12:0]      IMM_LIM  = 13'(MEM_IMM_LIMIT);
  localparam logic [3:0]       GAP_LOAD = 4'(STORE_GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               PC_RD0   = (PC_DEP_RD0 != 0);

  phase_t state, next_state;
  logic [3:0] gap_cnt;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12, simm;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm12  = instruction[31:20];
  assign simm   = {instruction[31:25], instruction[11:7]};

  logic rd_ok, rs1_ok, rs2_ok, pc_rd_ok;
  assign rd_ok    = {1'b0, rd}  < REG_LIM;
  assign rs1_ok   = {1'b0, rs1} < REG_LIM;
  assign rs2_ok   = {1'b0, rs2} < REG_LIM;
  assign pc_rd_ok = PC_RD0 ? (rd == 5'd0) : rd_ok;

  logic is_r, is_i, is_b, is_fence, is_sys, is_lui, is_load, is_store;
  logic is_jal, is_jalr, is_auipc, is_nop, legal_fmt;

  // Per-class decode against the configured register/immediate envelope
  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_b     = 1'b0;
    is_fence = 1'b0;
    is_sys   = 1'b0;
    is_lui   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_auipc = 1'b0;
    is_nop   = (opcode == 7'b1111111);
    case (opcode)
      7'b0110011: is_r = rd_ok && rs1_ok && rs2_ok &&
                         ((funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      7'b0010011: begin
        if (funct3 == 3'b001)
          is_i = rd_ok && rs1_ok && (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          is_i = rd_ok && rs1_ok && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
        else
          is_i = rd_ok && rs1_ok;
      end
      7'b1100011: is_b = rs1_ok && rs2_ok && (funct3 != 3'b010) && (funct3 != 3'b011);
      7'b0001111: is_fence = (funct3 == 3'b000);
      7'b1110011: is_sys = (funct3 == 3'b000) && (rs1 == 5'd0) && (rd == 5'd0) &&
                           (imm12 == 12'd0 || imm12 == 12'd1);
      7'b0110111: is_lui = rd_ok;
      7'b0000011: is_load = rd_ok && (rs1 == 5'd0) && ({1'b0, imm12} < IMM_LIM) &&
                            (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      7'b0100011: is_store = rs2_ok && (rs1 == 5'd0) && ({1'b0, simm} < IMM_LIM) &&
                             (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
      7'b1101111: is_jal = pc_rd_ok;
      7'b1100111: is_jalr = pc_rd_ok && rs1_ok && (funct3 == 3'b000);
      7'b0010111: is_auipc = pc_rd_ok;
      default: ;
    endcase
  end

  assign legal_fmt = is_r | is_i | is_b | is_fence | is_sys | is_lui | is_load |
                     is_store | is_jal | is_jalr | is_auipc | is_nop;

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ORIG;
    else        state <= next_state;
  end

  // Phase transitions and phase-gated legality
  always_comb begin
    next_state = state;
    allowed    = 1'b0;
    case (state)
      ORIG: begin
        allowed = legal_fmt && !is_store && (orig_cnt != CNT_MAX || is_nop);
        if (sif_commit) next_state = DUP;
      end
      DUP: begin
        allowed = legal_fmt && (!is_store || !store_block) && (dup_cnt != orig_cnt || is_nop);
        if (dup_cnt == orig_cnt) next_state = DONE;
      end
      DONE:    allowed = is_nop;
      default: next_state = ORIG;
    endcase
  end

  assign accept      = instr_valid && allowed;
  assign phase       = state;
  assign store_block = (gap_cnt != 4'd0);

  // Count accepted non-NOP instructions per phase; legality gating prevents wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_cnt <= '0;
      dup_cnt  <= '0;
    end else if (accept && !is_nop) begin
      if (state == ORIG)     orig_cnt <= orig_cnt + 1'b1;
      else if (state == DUP) dup_cnt  <= dup_cnt + 1'b1;
    end
  end

  // Store spacing window: reload on accepted store, otherwise drain to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  gap_cnt <= 4'd0;
    else if (accept && is_store) gap_cnt <= GAP_LOAD;
    else if (gap_cnt != 4'd0)    gap_cnt <= gap_cnt - 4'd1;
  end

endmodule

// File: tb/tb_qed_inst_constraint_seq.sv
// tb/tb_qed_inst_constraint_seq.sv - self-checking bench for qed_inst_constraint_seq
module tb_qed_inst_constraint_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'h0000007F;
  logic        instr_valid = 1'b0;
  logic        sif_commit = 1'b0;

  logic       allowed, accept, store_block;
  logic [1:0] phase;
  logic [4:0] orig_cnt, dup_cnt;

  logic       allowed32, accept32, store_block32;
  logic [1:0] phase32;
  logic [4:0] orig_cnt32, dup_cnt32;

  logic       allowed_s, accept_s, store_block_s;
  logic [1:0] phase_s;
  logic [1:0] orig_cnt_s, dup_cnt_s;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] SW  = 32'h00102023;
  localparam logic [31:0] NOP = 32'h0000007F;

  always #5 clk = ~clk;

  qed_inst_constraint_seq dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .sif_commit(sif_commit), .allowed(allowed), .accept(accept), .phase(phase),
    .orig_cnt(orig_cnt), .dup_cnt(dup_cnt), .store_block(store_block));

  qed_inst_constraint_seq #(.NUM_REGS(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .sif_commit(sif_commit), .allowed(allowed32), .accept(accept32), .phase(phase32),
    .orig_cnt(orig_cnt32), .dup_cnt(dup_cnt32), .store_block(store_block32));

  qed_inst_constraint_seq #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .sif_commit(sif_commit), .allowed(allowed_s), .accept(accept_s), .phase(phase_s),
    .orig_cnt(orig_cnt_s), .dup_cnt(dup_cnt_s), .store_block(store_block_s));

  typedef struct {
    logic [31:0] instr;
    logic        exp_allowed;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // present an instruction and let combinational outputs settle
  task automatic drive(input logic [31:0] ins, input logic v, input logic c);
    instruction = ins;
    instr_valid = v;
    sif_commit  = c;
    #1;
  endtask

  // advance one clock and sample just after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(NOP, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs.push_back('{32'h002081B3, 1'b1, "add"});
    vecs.push_back('{32'h00102023, 1'b0, "sw_in_orig"});
    vecs.push_back('{32'h00100813, 1'b0, "addi_x16"});
    vecs.push_back('{32'h0000007F, 1'b1, "nop"});
    vecs.push_back('{32'h008000EF, 1'b0, "jal_x1"});
    vecs.push_back('{32'h0080006F, 1'b1, "jal_x0"});
    vecs.push_back('{32'h04002103, 1'b0, "lw_imm64"});
    vecs.push_back('{32'h03C02103, 1'b1, "lw_imm60"});
    vecs.push_back('{32'h0000A103, 1'b0, "lw_rs1_nz"});
    vecs.push_back('{32'h402081B3, 1'b1, "sub"});
    vecs.push_back('{32'h022081B3, 1'b0, "r_bad_f7"});
    vecs.push_back('{32'h4030D093, 1'b1, "srai"});
    vecs.push_back('{32'h40309093, 1'b0, "slli_bad_f7"});
    vecs.push_back('{32'h00000073, 1'b1, "ecall"});
    vecs.push_back('{32'h00100073, 1'b1, "ebreak"});
    vecs.push_back('{32'h000000F3, 1'b0, "ecall_rd1"});
    vecs.push_back('{32'h00208063, 1'b1, "beq"});
    vecs.push_back('{32'h0020A063, 1'b0, "branch_f3_010"});
    vecs.push_back('{32'h000012B7, 1'b1, "lui_x5"});
    vecs.push_back('{32'h000018B7, 1'b0, "lui_x17"});
    vecs.push_back('{32'h00000017, 1'b1, "auipc_x0"});
    vecs.push_back('{32'h00000097, 1'b0, "auipc_x1"});
    vecs.push_back('{32'h00008067, 1'b1, "jalr_x0"});
    vecs.push_back('{32'h0FF0000F, 1'b1, "fence"});
    vecs.push_back('{32'h00000000, 1'b0, "all_zero"});

    do_reset();
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_orig", 32'(orig_cnt), 32'd0);
    chk("reset_dup", 32'(dup_cnt), 32'd0);
    chk("reset_block", 32'(store_block), 32'd0);

    // decode table in ORIG with no issue, so state stays at reset values
    foreach (vecs[i]) begin
      drive(vecs[i].instr, 1'b0, 1'b0);
      chk(vecs[i].name, 32'(allowed), 32'(vecs[i].exp_allowed));
    end
    drive(32'h00100813, 1'b0, 1'b0);
    chk("addi_x16_nregs32", 32'(allowed32), 32'd1);
    chk("no_issue_orig", 32'(orig_cnt), 32'd0);

    // ORIG accumulation and saturation of the narrow-counter instance
    drive(ADD, 1'b1, 1'b0);
    chk("add_allowed", 32'(allowed), 32'd1);
    tick();
    chk("orig_after_1", 32'(orig_cnt), 32'd1);
    chk("phase_after_1", 32'(phase), 32'd0);
    drive(ADD, 1'b1, 1'b0);
    tick();
    drive(ADD, 1'b1, 1'b0);
    tick();
    chk("orig_after_3", 32'(orig_cnt), 32'd3);
    chk("sat_orig_3", 32'(orig_cnt_s), 32'd3);
    drive(ADD, 1'b0, 1'b0);
    chk("sat_add_blocked", 32'(allowed_s), 32'd0);
    chk("wide_add_ok", 32'(allowed), 32'd1);
    drive(NOP, 1'b0, 1'b0);
    chk("sat_nop_ok", 32'(allowed_s), 32'd1);
    drive(SW, 1'b1, 1'b0);
    chk("sw_orig_blocked", 32'(allowed), 32'd0);
    tick();
    chk("sw_orig_no_count", 32'(orig_cnt), 32'd3);

    // commit into DUP, then store spacing
    drive(NOP, 1'b0, 1'b1);
    tick();
    chk("phase_dup", 32'(phase), 32'd1);
    drive(SW, 1'b1, 1'b0);
    chk("sw_dup_ok", 32'(allowed), 32'd1);
    tick();
    chk("dup_after_sw", 32'(dup_cnt), 32'd1);
    chk("block_cyc1", 32'(store_block), 32'd1);
    drive(SW, 1'b1, 1'b0);
    chk("sw_blocked_1", 32'(allowed), 32'd0);
    tick();
    chk("block_cyc2", 32'(store_block), 32'd1);
    drive(SW, 1'b1, 1'b0);
    chk("sw_blocked_2", 32'(allowed), 32'd0);
    tick();
    chk("block_clear", 32'(store_block), 32'd0);
    drive(SW, 1'b1, 1'b0);
    chk("sw_third_ok", 32'(allowed), 32'd1);
    tick();
    chk("dup_after_sw2", 32'(dup_cnt), 32'd2);
    drive(NOP, 1'b0, 1'b0);
    tick();
    tick();
    chk("block_drained", 32'(store_block), 32'd0);
    drive(ADD, 1'b1, 1'b0);
    tick();
    chk("dup_balanced", 32'(dup_cnt), 32'd3);
    chk("still_dup", 32'(phase), 32'd1);
    drive(ADD, 1'b0, 1'b0);
    chk("add_balanced_blocked", 32'(allowed), 32'd0);
    tick();
    chk("phase_done", 32'(phase), 32'd2);
    chk("done_add_blocked", 32'(allowed), 32'd0);
    drive(NOP, 1'b1, 1'b1);
    chk("done_nop_ok", 32'(allowed), 32'd1);
    tick();
    chk("done_terminal", 32'(phase), 32'd2);
    chk("done_dup_hold", 32'(dup_cnt), 32'd3);

    // orig_cnt == 0: exactly one DUP cycle
    do_reset();
    drive(NOP, 1'b0, 1'b1);
    tick();
    chk("empty_dup", 32'(phase), 32'd1);
    drive(NOP, 1'b0, 1'b0);
    tick();
    chk("empty_done", 32'(phase), 32'd2);

    // instruction accepted in commit cycle counts; async reset mid-DUP
    do_reset();
    drive(ADD, 1'b1, 1'b0);
    tick();
    drive(ADD, 1'b1, 1'b1);
    tick();
    chk("commit_cycle_counts", 32'(orig_cnt), 32'd2);
    chk("commit_phase", 32'(phase), 32'd1);
    drive(SW, 1'b1, 1'b0);
    tick();
    chk("pre_reset_dup", 32'(dup_cnt), 32'd1);
    chk("pre_reset_block", 32'(store_block), 32'd1);
    drive(NOP, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_orig", 32'(orig_cnt), 32'd0);
    chk("async_dup", 32'(dup_cnt), 32'd0);
    chk("async_block", 32'(store_block), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
